// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the EX stage and the RV32M multiply/divide sequencer.
interface muldiv_sequencer_if;
    logic        START;
    logic [2:0]  OP;
    logic [31:0] DATA1;
    logic [31:0] DATA2;
    logic        ABORT;
    logic [31:0] RESULT;
    logic        VALID;
    logic        STALL;

    modport master (
        output START, OP, DATA1, DATA2, ABORT,
        input  RESULT, VALID, STALL
    );

    modport slave (
        input  START, OP, DATA1, DATA2, ABORT,
        output RESULT, VALID, STALL
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer: 32-step shift-add multiply and
// restoring divide on operand magnitudes, with the sign applied on the final step.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic                CLK,
    input  logic                RESET,
    muldiv_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic [XLEN-1:0]     opa_q, opa_d;      // multiplicand (MUL) or divisor (DIV) magnitude
    logic [2*XLEN-1:0]   acc_q, acc_d;      // MUL: {high, multiplier}; DIV: {remainder, dividend/quotient}
    logic                neg_q, neg_d;      // product/quotient must be negated
    logic                rneg_q, rneg_d;    // remainder must be negated
    logic [XLEN-1:0]     result_q, result_d;

    logic                start_ok_s;
    logic                div_zero_s;
    logic                div_ovf_s;
    logic                fast_s;
    logic                signed1_s, signed2_s;
    logic                s1_s, s2_s;
    logic [XLEN-1:0]     mag1_s, mag2_s;
    logic [XLEN:0]       mul_sum_s;
    logic [2*XLEN-1:0]   mul_next_s;
    logic [XLEN:0]       div_shift_s;
    logic                div_ge_s;
    logic [XLEN-1:0]     div_rem_s;
    logic [2*XLEN-1:0]   div_next_s;
    logic [2*XLEN-1:0]   product_s;
    logic [XLEN-1:0]     quot_s, rem_s;
    logic [XLEN-1:0]     fin_result_s;
    logic [XLEN-1:0]     fast_result_s;

    // Decode of the incoming request: acceptance, special divide cases, operand signs.
    always_comb begin
        start_ok_s = (state_q == ST_IDLE) && bus.START && !bus.ABORT;
        div_zero_s = bus.OP[2] && (bus.DATA2 == 32'h0000_0000);
        div_ovf_s  = bus.OP[2] && !bus.OP[0] &&
                     (bus.DATA1 == 32'h8000_0000) && (bus.DATA2 == 32'hFFFF_FFFF);
        fast_s     = div_zero_s || div_ovf_s;
        // rs1 is signed for MUL, MULH, MULHSU, DIV, REM; rs2 also, except for MULHSU.
        signed1_s  = !((bus.OP == 3'b011) || (bus.OP[2] && bus.OP[0]));
        signed2_s  = signed1_s && (bus.OP != 3'b010);
        s1_s       = signed1_s && bus.DATA1[31];
        s2_s       = signed2_s && bus.DATA2[31];
        mag1_s     = s1_s ? (~bus.DATA1 + 32'd1) : bus.DATA1;
        mag2_s     = s2_s ? (~bus.DATA2 + 32'd1) : bus.DATA2;
        if (bus.OP[1]) begin
            fast_result_s = div_zero_s ? bus.DATA1 : 32'h0000_0000;
        end else begin
            fast_result_s = div_zero_s ? 32'hFFFF_FFFF : 32'h8000_0000;
        end
    end

    // One iteration of each algorithm plus sign fix and result select for the last step.
    always_comb begin
        mul_sum_s   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opa_q} : 33'd0);
        mul_next_s  = {mul_sum_s, acc_q[31:1]};
        div_shift_s = {acc_q[63:32], acc_q[31]};
        div_ge_s    = (div_shift_s >= {1'b0, opa_q});
        div_rem_s   = div_ge_s ? (div_shift_s[31:0] - opa_q) : div_shift_s[31:0];
        div_next_s  = {div_rem_s, acc_q[30:0], div_ge_s};
        product_s   = neg_q  ? (~mul_next_s + 64'd1) : mul_next_s;
        quot_s      = neg_q  ? (~div_next_s[31:0] + 32'd1) : div_next_s[31:0];
        rem_s       = rneg_q ? (~div_next_s[63:32] + 32'd1) : div_next_s[63:32];
        if (state_q == ST_MUL) begin
            fin_result_s = (op_q == 3'b000) ? product_s[31:0] : product_s[63:32];
        end else begin
            fin_result_s = op_q[1] ? rem_s : quot_s;
        end
    end

    // Next-state logic of the sequencing FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) begin
                    if (!bus.OP[2]) begin
                        state_d = ST_MUL;
                    end else if (fast_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DIV;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (bus.ABORT) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 6'd31) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: operand latch, per-step update and result capture.
    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        opa_d    = opa_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) begin
                    op_d   = bus.OP;
                    cnt_d  = 6'd0;
                    neg_d  = s1_s ^ s2_s;
                    rneg_d = s1_s;
                    if (!bus.OP[2]) begin
                        opa_d = mag1_s;
                        acc_d = {32'd0, mag2_s};
                    end else begin
                        opa_d = mag2_s;
                        acc_d = {32'd0, mag1_s};
                    end
                    if (bus.OP[2] && fast_s) begin
                        result_d = fast_result_s;
                    end else begin
                        result_d = result_q;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_MUL, ST_DIV: begin
                if (bus.ABORT) begin
                    cnt_d = 6'd0;
                end else begin
                    acc_d = (state_q == ST_MUL) ? mul_next_s : div_next_s;
                    if (cnt_q == 6'd31) begin
                        cnt_d    = 6'd0;
                        result_d = fin_result_s;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            ST_DONE: cnt_d = 6'd0;
            default: cnt_d = 6'd0;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            cnt_q    <= 6'd0;
            op_q     <= 3'd0;
            opa_q    <= 32'd0;
            acc_q    <= 64'd0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= 32'd0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    // Outputs: VALID marks the DONE cycle, STALL holds the pipeline until then.
    always_comb begin
        bus.RESULT = result_q;
        bus.VALID  = (state_q == ST_DONE);
        bus.STALL  = start_ok_s || (state_q == ST_MUL) || (state_q == ST_DIV);
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer against a plain-arithmetic RV32M model.
module tb_muldiv_sequencer;

    logic CLK;
    logic RESET;
    int   tests_run;
    int   tests_failed;
    logic [31:0] model_last;

    muldiv_sequencer_if bus ();

    muldiv_sequencer #(.XLEN(32)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // RV32M result computed from the instruction definitions with 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        logic [31:0] r;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = 64'd0;
        case (op)
            3'd0: begin p = sa * sb; r = p[31:0];  end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: r = (b == 32'd0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 32'd0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default: r = (b == 32'd0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pick();
        int sel;
        sel = $urandom_range(0, 5);
        case (sel)
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Issue one operation; hold keeps START high with changing operands until completion.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit hold);
        logic [31:0] exp_r;
        int exp_lat, k, stall_n;
        bit seen;
        exp_r   = ref_result(op, a, b);
        exp_lat = (op[2] && ((b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 33;
        @(negedge CLK);
        bus.START = 1'b1; bus.OP = op; bus.DATA1 = a; bus.DATA2 = b;
        #1;
        stall_n = bus.STALL ? 1 : 0;
        @(posedge CLK);
        seen = 1'b0;
        k = 0;
        while (!seen && k < 40) begin
            @(negedge CLK);
            k++;
            if (bus.VALID) begin
                seen = 1'b1;
                check_eq("stall_in_done", 32'(bus.STALL), 32'd0);
                check_eq("result", bus.RESULT, exp_r);
                bus.START = 1'b0;
            end else begin
                if (bus.STALL) stall_n++;
                if (hold) begin
                    bus.OP = 3'($urandom); bus.DATA1 = $urandom; bus.DATA2 = $urandom;
                end else begin
                    bus.START = 1'b0;
                end
            end
        end
        bus.START = 1'b0;
        check_eq("valid_seen", 32'(seen), 32'd1);
        check_eq("latency", 32'(k), 32'(exp_lat));
        check_eq("stall_cycles", 32'(stall_n), 32'(exp_lat));
        @(negedge CLK);
        check_eq("valid_once", 32'(bus.VALID), 32'd0);
        check_eq("idle_stall", 32'(bus.STALL), 32'd0);
        model_last = exp_r;
    endtask

    // Start an operation and disturb it with ABORT or RESET at cycle cut.
    task automatic cut_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int cut, input bit use_reset);
        int vcount;
        vcount = 0;
        @(negedge CLK);
        bus.START = 1'b1; bus.OP = op; bus.DATA1 = a; bus.DATA2 = b;
        @(posedge CLK);
        for (int k = 1; k <= cut; k++) begin
            @(negedge CLK);
            bus.START = 1'b0;
            if (bus.VALID) vcount++;
        end
        if (use_reset) RESET = 1'b0; else bus.ABORT = 1'b1;
        @(negedge CLK);
        if (use_reset) model_last = 32'd0;
        check_eq(use_reset ? "rst_valid" : "abort_valid", 32'(bus.VALID), 32'd0);
        check_eq(use_reset ? "rst_stall" : "abort_stall", 32'(bus.STALL), 32'd0);
        check_eq(use_reset ? "rst_result" : "abort_result", bus.RESULT, model_last);
        RESET = 1'b1;
        bus.ABORT = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (bus.VALID) vcount++;
        end
        check_eq("no_valid_after_cut", 32'(vcount), 32'd0);
        check_eq("result_after_cut", bus.RESULT, model_last);
    endtask

    initial begin
        tests_run = 0; tests_failed = 0; model_last = 32'd0;
        RESET = 1'b0;
        bus.START = 1'b0; bus.OP = 3'd0; bus.DATA1 = 32'd0; bus.DATA2 = 32'd0; bus.ABORT = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        check_eq("reset_result", bus.RESULT, 32'd0);
        check_eq("reset_valid", 32'(bus.VALID), 32'd0);
        check_eq("reset_stall", 32'(bus.STALL), 32'd0);

        run_op(3'b000, 32'd7, 32'd6, 1'b0);
        run_op(3'b001, 32'hFFFF_FFFE, 32'd3, 1'b0);
        run_op(3'b011, 32'hFFFF_FFFE, 32'd3, 1'b0);
        run_op(3'b010, 32'hFFFF_FFFE, 32'd3, 1'b0);
        run_op(3'b100, 32'hFFFF_FFE5, 32'd5, 1'b0);
        run_op(3'b110, 32'hFFFF_FFE5, 32'd5, 1'b0);
        run_op(3'b101, 32'd27, 32'd5, 1'b0);
        run_op(3'b111, 32'd27, 32'd5, 1'b0);
        run_op(3'b100, 32'd10, 32'd0, 1'b0);
        run_op(3'b111, 32'd10, 32'd0, 1'b0);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        cut_op(3'b100, 32'd1000, 32'd7, 10, 1'b0);
        run_op(3'b000, 32'd3, 32'd4, 1'b0);
        cut_op(3'b000, 32'd9, 32'd9, 10, 1'b1);
        run_op(3'b000, 32'd7, 32'd6, 1'b1);

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), pick(), pick(), (i % 5) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative sequencer for the RV32M multiply/divide operations that the single-cycle ALU does not handle. It sits beside the ALU in the EX stage. On a START request it latches both operands and runs a 32-step shift-add multiply or restoring divide. While it runs it holds the pipeline with STALL, then presents a registered RESULT with a one-cycle VALID pulse.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- CLK  input  1  rising-edge clock.
- RESET  input  1  synchronous, active-low reset, sampled on the rising edge of CLK.
- START  input  1  request; sampled only in IDLE.
- OP  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- DATA1  input  32  rs1 operand (multiplicand/dividend); latched when START is accepted.
- DATA2  input  32  rs2 operand (multiplier/divisor); latched when START is accepted.
- ABORT  input  1  pipeline flush; cancels any operation in progress.
- RESULT  output  32  registered result; holds its last value until the next completion.
- VALID  output  1  one-cycle pulse; RESULT is valid in that cycle.
- STALL  output  1  combinational: (state==IDLE & START & !ABORT) | state==MUL | state==DIV.

## Operation
- States: IDLE, MUL, DIV, DONE. 6-bit step counter CNT.
- IDLE
  - START=1 and ABORT=0: latch OP and operands, CNT←0, then branch on OP:
    - OP[2]=0: go to MUL.
    - OP[2]=1, divisor==0: fast path to DONE. Quotient = 32'hFFFFFFFF; remainder = DATA1.
    - OP[2]=1, signed DIV/REM with DATA1==32'h80000000 and DATA2==32'hFFFFFFFF: fast path to DONE. Quotient = 32'h80000000; remainder = 0.
    - Otherwise: go to DIV.
- Sign handling
  - Signed operands are converted to magnitudes at latch time:
    - MUL, MULH, DIV, REM: both operands signed.
    - MULHSU: DATA1 signed, DATA2 unsigned.
    - MULHU, DIVU, REMU: unsigned.
  - Result signs:
    - Product sign = XOR of the operand signs.
    - Quotient sign = XOR of the operand signs.
    - Remainder sign = dividend sign.
- MUL: one step per cycle. If multiplier LSB=1, add the multiplicand to the upper half of a 64-bit accumulator. Then shift right by 1.
- DIV: restoring divide, one quotient bit per cycle, with a 33-bit partial remainder.
- Completion: after step 32 (CNT==31 at the edge), go to DONE. On that edge, apply the sign fix (two's-complement negate) and select RESULT:
  - MUL: product[31:0].
  - MULH, MULHSU, MULHU: product[63:32].
  - DIV, DIVU: quotient.
  - REM, REMU: remainder.
- DONE: VALID=1 for one cycle, then go to IDLE unconditionally. START in DONE is ignored; the requester re-asserts it.
- ABORT=1 in any state: go to IDLE next edge, no VALID. An aborting START is not accepted. RESULT is not updated.
- START while in MUL, DIV or DONE: ignored. Operand changes after acceptance have no effect.

## Timing
- Reset (RESET=0 at an edge): state=IDLE, CNT=0, RESULT=0, VALID=0. STALL=0 after reset unless START is high. Reset mid-operation discards the operation.
- Normal latency: START accepted at edge e0; iterations at edges e1..e32; VALID is high in the cycle after e32, i.e. 33 cycles after the START cycle.
- Fast path (divide-by-zero or overflow): VALID is high in the cycle after e0 (latency 1).
- STALL is high from the START cycle through the last MUL/DIV cycle. It is low in the DONE cycle, so the stalled instruction advances with VALID.
- Back-to-back: the earliest next START is accepted at the edge after DONE. There is one dead IDLE cycle between operations.
- Arithmetic is modulo 2^32 on RESULT. The full 64-bit product is computed internally with no truncation before the high/low select.

## Test plan
- MUL: DATA1=7, DATA2=6, OP=000 -> STALL high for 33 cycles; VALID exactly once, 33 cycles after START; RESULT=42.
- MULH signed: DATA1=32'hFFFFFFFE (-2), DATA2=3 -> RESULT=32'hFFFFFFFF. MULHU with the same operands -> RESULT=2. MULHSU with the same operands -> RESULT=32'hFFFFFFFF.
- DIV/REM signed: DATA1=-27, DATA2=5 -> DIV RESULT=-5 (32'hFFFFFFFB); REM RESULT=-2 (32'hFFFFFFFE). DIVU 27/5=5; REMU 27%5=2.
- Fast paths:
  - DIV 10/0: VALID in the cycle after START, RESULT=32'hFFFFFFFF.
  - REMU 10/0: RESULT=10.
  - DIV 32'h80000000/32'hFFFFFFFF: RESULT=32'h80000000.
  - REM with the same operands: RESULT=0.
- ABORT at cycle 10 of a DIV -> no VALID, RESULT unchanged, IDLE next cycle. A new MUL 3*4 then completes with RESULT=12.
- RESET=0 mid-MUL -> RESULT=0, VALID=0, STALL=0. A START held high during MUL with changed operands is ignored and the original result is returned.
